// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use and taken-branch hazards, multi-cycle
// mul/div occupancy of EX, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_md_start_i,
    input  logic              branch_taken_i,
    output logic              pc_we_o,
    output logic              ifid_we_o,
    output logic              ifid_flush_o,
    output logic              idex_we_o,
    output logic              idex_flush_o,
    output logic              exmem_flush_o,
    output logic              md_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;
    localparam bit         MD_MULTI   = (MD_LAT > 1);
    // The start cycle and the release cycle are not counted down.
    localparam logic [3:0] MD_LOAD    = MD_MULTI ? 4'(MD_LAT - 2) : 4'd0;

    logic [0:0]       fsm_q, fsm_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    always_comb begin
        load_use = ex_memread_i && (ex_rd_i != '0) &&
                   ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        fsm_d         = fsm_q;
        md_cnt_d      = md_cnt_q;

        if (rst_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            fsm_d         = ST_RUN;
            md_cnt_d      = 4'd0;
        end else if (fsm_q == ST_MD_BUSY) begin
            // The mul/div is still in EX: new starts and branches belong to it and are ignored.
            if (md_cnt_q != 4'd0) begin
                pc_we_o       = 1'b0;
                ifid_we_o     = 1'b0;
                idex_we_o     = 1'b0;
                exmem_flush_o = 1'b1;
                md_cnt_d      = md_cnt_q - 4'd1;
            end else begin
                fsm_d = ST_RUN;
            end
        end else if (ex_md_start_i && MD_MULTI) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_flush_o = 1'b1;
            fsm_d         = ST_MD_BUSY;
            md_cnt_d      = MD_LOAD;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
        end

        md_busy_o = (fsm_q == ST_MD_BUSY) && !rst_i;

        stall_cnt_d = stall_cnt_q;
        if (rst_i) begin
            stall_cnt_d = '0;
        end else if (!pc_we_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= ST_RUN;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written corner
// sequences, and randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
    logic              id_uses_rt, ex_memread, ex_md_start, branch_taken;
    logic              pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .ex_memread_i   (ex_memread),
        .ex_rd_i        (ex_rd),
        .ex_md_start_i  (ex_md_start),
        .branch_taken_i (branch_taken),
        .pc_we_o        (pc_we),
        .ifid_we_o      (ifid_we),
        .ifid_flush_o   (ifid_flush),
        .idex_we_o      (idex_we),
        .idex_flush_o   (idex_flush),
        .exmem_flush_o  (exmem_flush),
        .md_busy_o      (md_busy),
        .stall_cnt_o    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles the mul/div still has to spend in EX, and stall total.
    int         md_left = 0;
    int         sc      = 0;
    logic [5:0] exp_ctl;    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush}
    logic       exp_busy;

    localparam logic [5:0] C_DEF  = 6'b110100;
    localparam logic [5:0] C_RST  = 6'b001011;
    localparam logic [5:0] C_MD   = 6'b000001;
    localparam logic [5:0] C_BR   = 6'b111110;
    localparam logic [5:0] C_LU   = 6'b000110;

    function automatic logic [5:0] act_ctl();
        return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush};
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive(input logic r, input logic mr, input int rd, input int rs, input int rt,
                         input logic ut, input logic md, input logic br, input bit chk);
        bit lu;
        rst = r; ex_memread = mr; ex_rd = REG_AW'(rd); id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
        id_uses_rt = ut; ex_md_start = md; branch_taken = br;
        #1;
        lu = mr && (rd != 0) && (rd == rs || (ut && rd == rt));
        exp_busy = 1'b0;
        if (r)                          exp_ctl = C_RST;
        else if (md_left > 1)      begin exp_ctl = C_MD;  exp_busy = 1'b1; end
        else if (md_left == 1)     begin exp_ctl = C_DEF; exp_busy = 1'b1; end
        else if (md && MD_LAT > 1)      exp_ctl = C_MD;
        else if (br)                    exp_ctl = C_BR;
        else if (lu)                    exp_ctl = C_LU;
        else                            exp_ctl = C_DEF;
        if (chk) begin
            check("ctl", act_ctl(), exp_ctl);
            check("md_busy", md_busy, exp_busy);
            check("stall_cnt", stall_cnt, sc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            md_left = 0;
            sc      = 0;
        end else begin
            if (md_left > 0)                      md_left--;
            else if (ex_md_start && MD_LAT > 1)   md_left = MD_LAT - 1;
            if (!exp_ctl[5] && sc < CNT_MAX)      sc++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
    endtask

    typedef struct {
        logic       mr;
        int         rd, rs, rt;
        logic       ut, md, br;
        logic [5:0] ctl;
        string      name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int c0;
        rst = 1'b1; ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
        id_uses_rt = 0; ex_md_start = 0; branch_taken = 0;
        exp_ctl = C_RST; exp_busy = 0;

        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, C_DEF, "idle"};
        vecs[1] = '{1, 8, 8, 3, 0, 0, 0, C_LU,  "lu_rs"};
        vecs[2] = '{1, 0, 0, 0, 1, 0, 0, C_DEF, "lu_r0"};
        vecs[3] = '{1, 8, 3, 8, 0, 0, 0, C_DEF, "rt_unused"};
        vecs[4] = '{1, 8, 3, 8, 1, 0, 0, C_LU,  "lu_rt"};
        vecs[5] = '{0, 8, 8, 8, 1, 0, 0, C_DEF, "no_load"};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 1, C_BR,  "branch"};
        vecs[7] = '{1, 8, 8, 0, 0, 0, 1, C_BR,  "branch_lu"};
        vecs[8] = '{0, 0, 0, 0, 0, 1, 0, C_MD,  "md_start"};
        vecs[9] = '{1, 8, 8, 0, 0, 1, 1, C_MD,  "md_br_lu"};

        @(negedge clk);

        // Reset behaviour
        do_reset(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        check("rst_cnt", stall_cnt, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rel_pc_we", pc_we, 1);
        check("rel_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b000);
        tick();
        $display("reset sequence done, cmp=%0d", n_cmp);

        // Single-cycle table, each vector from a freshly reset RUN state
        for (int i = 0; i < 10; i++) begin
            do_reset(1);
            drive(0, vecs[i].mr, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                  vecs[i].ut, vecs[i].md, vecs[i].br, 1);
            check({"vec_", vecs[i].name}, act_ctl(), vecs[i].ctl);
            check({"vec_busy_", vecs[i].name}, md_busy, 0);
            $display("vector %0d %s ctl=%b", i, vecs[i].name, act_ctl());
            tick();
        end

        // Load-use: one bubble, counted once; r0 and unused rt never stall
        do_reset(1);
        drive(0, 1, 8, 8, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("lu_cnt", stall_cnt, 1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        check("lu_r0_pc_we", pc_we, 1);
        tick();
        drive(0, 1, 8, 0, 8, 0, 0, 0, 1);
        check("lu_rt_unused_pc_we", pc_we, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("lu_cnt_hold", stall_cnt, 1);
        tick();
        $display("load-use sequence done, cnt=%0d", stall_cnt);

        // MD_LAT=4 with start held: 3 stalls, busy in cycles 2-4, release in cycle 4
        do_reset(1);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
            check($sformatf("md_busy_c%0d", k), md_busy, (k >= 2));
            check($sformatf("md_pc_we_c%0d", k), pc_we, (k == 4));
            check($sformatf("md_exmem_c%0d", k), exmem_flush, (k != 4));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("md_cnt", stall_cnt, 3);
        check("md_busy_after", md_busy, 0);
        tick();
        $display("md sequence done, cnt=%0d", stall_cnt);

        // Branch together with load-use
        c0 = int'(stall_cnt);
        drive(0, 1, 8, 8, 0, 0, 0, 1, 1);
        check("brlu_flushes", {ifid_flush, idex_flush}, 2'b11);
        check("brlu_pc_we", pc_we, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("brlu_cnt", stall_cnt, c0);
        tick();
        $display("branch vs load-use done");

        // Branch in the 2nd stall cycle is ignored
        do_reset(1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("mdbr_pc_we", pc_we, 0);
        check("mdbr_ifid_flush", ifid_flush, 0);
        check("mdbr_busy", md_busy, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("mdbr_c3_pc_we", pc_we, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("mdbr_rel_ctl", act_ctl(), C_DEF);
        tick();
        $display("branch during md done");

        // Reset in the 2nd stall cycle abandons the operation
        do_reset(1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("mdrst_busy", md_busy, 0);
        check("mdrst_pc_we", pc_we, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("mdrst_restart_cnt", stall_cnt, 3);
        tick();
        $display("reset during md done");

        // Randomized traffic against the model
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), 1);
            tick();
        end
        $display("random phase done, cmp=%0d bad=%0d", n_cmp, n_bad);

        // Saturation of the stall counter
        do_reset(1);
        for (int i = 0; i < CNT_MAX + 10; i++) begin
            drive(0, 1, 8, 8, 0, 0, 0, 0, (i % 1024) == 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("sat_cnt", stall_cnt, CNT_MAX);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8, 8, 0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("sat_hold", stall_cnt, CNT_MAX);
        tick();
        $display("saturation done, cnt=%0d", stall_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
